// File: rtl/uart_tx_arbiter.sv
// Four-requester UART transmitter: round-robin arbiter with message locking
// and lock timeout feeding a single 8N1 serializer (LSB first, idle high).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid[3:0]      per-requester byte offer
//   req_data[31:0]      requester i byte on [8i+7:8i]
//   req_last[3:0]       end-of-message flag, qualified by req_valid
//   req_ready[3:0]      one-cycle accept pulse (combinational, one-hot)
//   grant[3:0]          one-hot current owner, zero when unowned
//   uartTx              registered serial line
//   busy                high while a frame is on the line
//   lock_timeout        one-cycle pulse when an idle lock is revoked
module uart_tx_arbiter #(
    parameter int DELAY_FRAMES = 234,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    output logic [3:0]  grant,
    output logic        uartTx,
    output logic        busy,
    output logic        lock_timeout
);

    typedef enum logic [1:0] {
        ARB,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [12:0] BIT_END  = 13'(DELAY_FRAMES - 1);
    localparam logic [15:0] IDLE_END = 16'(LOCK_TIMEOUT);

    state_t      state;
    logic [12:0] bitCnt;
    logic [2:0]  bitIdx;
    logic [7:0]  txData;
    logic        txLast;
    logic [1:0]  owner;
    logic        locked;
    logic [1:0]  rrPtr;
    logic [15:0] idleCnt;

    logic        pickValid;
    logic [1:0]  pickIdx;
    logic        accept;
    logic        bitDone;
    logic [15:0] idleNext;

    // Rotating priority: scanning offsets high to low lets the
    // lowest offset from rrPtr win. A held lock masks everyone else.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = rrPtr;
        if (locked) begin
            pickValid = req_valid[owner];
            pickIdx   = owner;
        end else begin
            for (int k = 3; k >= 0; k--) begin
                if (req_valid[rrPtr + 2'(k)]) begin
                    pickValid = 1'b1;
                    pickIdx   = rrPtr + 2'(k);
                end
            end
        end
    end

    // rst_n gates the pulse so no accept is shown while held in reset.
    assign accept    = rst_n && (state == ARB) && pickValid;
    assign req_ready = accept ? (4'b0001 << pickIdx) : 4'b0000;
    assign bitDone   = (bitCnt == BIT_END);
    assign idleNext  = idleCnt + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ARB;
            bitCnt       <= '0;
            bitIdx       <= '0;
            txData       <= '0;
            txLast       <= 1'b0;
            owner        <= '0;
            locked       <= 1'b0;
            rrPtr        <= '0;
            idleCnt      <= '0;
            grant        <= '0;
            uartTx       <= 1'b1;
            busy         <= 1'b0;
            lock_timeout <= 1'b0;
        end else begin
            lock_timeout <= 1'b0;
            unique case (state)
                ARB: begin
                    bitCnt <= '0;
                    bitIdx <= '0;
                    if (accept) begin
                        txData  <= req_data[{pickIdx, 3'b000} +: 8];
                        txLast  <= req_last[pickIdx];
                        owner   <= pickIdx;
                        grant   <= 4'b0001 << pickIdx;
                        idleCnt <= '0;
                        uartTx  <= 1'b0;
                        busy    <= 1'b1;
                        state   <= START;
                    end else if (locked) begin
                        if (idleNext == IDLE_END) begin
                            locked       <= 1'b0;
                            grant        <= '0;
                            rrPtr        <= owner + 2'd1;
                            idleCnt      <= '0;
                            lock_timeout <= 1'b1;
                        end else begin
                            idleCnt <= idleNext;
                        end
                    end
                end
                START: begin
                    if (bitDone) begin
                        bitCnt <= '0;
                        uartTx <= txData[0];
                        state  <= DATA;
                    end else begin
                        bitCnt <= bitCnt + 13'd1;
                    end
                end
                DATA: begin
                    if (bitDone) begin
                        bitCnt <= '0;
                        if (bitIdx == 3'd7) begin
                            uartTx <= 1'b1;
                            state  <= STOP;
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                            uartTx <= txData[bitIdx + 3'd1];
                        end
                    end else begin
                        bitCnt <= bitCnt + 13'd1;
                    end
                end
                STOP: begin
                    if (bitDone) begin
                        bitCnt <= '0;
                        busy   <= 1'b0;
                        state  <= ARB;
                        if (txLast) begin
                            locked <= 1'b0;
                            grant  <= '0;
                            rrPtr  <= owner + 2'd1;
                        end else begin
                            locked <= 1'b1;
                        end
                    end else begin
                        bitCnt <= bitCnt + 13'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DELAY_FRAMES, default 234, clk cycles per UART bit (115200 baud); legal range 2..8191.
REQ-002 Parameter LOCK_TIMEOUT, default 4096, idle clk cycles a locked owner may stall before its lock is revoked; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  4  per-requester byte-offer flag, bit i = requester i.
REQ-006 req_data  input  32  per-requester byte, requester i on bits [8i+7:8i].
REQ-007 req_last  input  4  per-requester end-of-message flag, qualified by req_valid.
REQ-008 req_ready  output  4  one-cycle accept pulse, at most one bit set.
REQ-009 grant  output  4  one-hot current owner, all zero when unowned.
REQ-010 uartTx  output  1  serial line, 8N1, LSB first, idle high.
REQ-011 busy  output  1  high while a frame is on the line (START/DATA/STOP).
REQ-012 lock_timeout  output  1  one-cycle pulse when a lock is revoked.

Function
REQ-013 FSM states: ARB, START, DATA, STOP; single bit-period counter (13 bits) and 3-bit bit index.
REQ-014 ARB, unlocked: if any req_valid, select first set bit scanning from rr_ptr upward, mod 4; else stay in ARB.
REQ-015 ARB, locked: only the lock owner is eligible; other req_valid bits are ignored regardless of priority.
REQ-016 On selection in ARB: req_ready[i] high that cycle, req_data byte and req_last[i] captured, grant = one-hot i, next state START.
REQ-017 A requester holds req_valid/req_data/req_last stable until its req_ready pulse; the block never accepts on a cycle where req_valid[i] is low.
REQ-018 START: uartTx = 0 for exactly DELAY_FRAMES cycles, then DATA with bit index 0.
REQ-019 DATA: uartTx = captured bit[index] for DELAY_FRAMES cycles per bit, index 0..7, then STOP.
REQ-020 STOP: uartTx = 1 for DELAY_FRAMES cycles, then ARB.
REQ-021 Frame length: 1 ARB cycle + 10*DELAY_FRAMES cycles; back-to-back accepts are therefore 10*DELAY_FRAMES+1 cycles apart.
REQ-022 uartTx is registered; it is 1 in ARB.
REQ-023 On leaving STOP with captured last=0: lock to owner, grant stays asserted, rr_ptr unchanged.
REQ-024 On leaving STOP with captured last=1: lock released, grant = 0, rr_ptr = (owner+1) mod 4.
REQ-025 Lock idle counter counts ARB cycles while locked and owner's req_valid low; cleared on any accept.
REQ-026 When lock idle counter reaches LOCK_TIMEOUT: lock released, grant = 0, rr_ptr = (owner+1) mod 4, lock_timeout pulses one cycle; arbitration resumes the next cycle.
REQ-027 req_valid changes during START/DATA/STOP have no effect on the frame in flight.
REQ-028 busy = 1 exactly in START, DATA, STOP.

Reset
REQ-029 rst_n low forces immediately, regardless of clk: state ARB, uartTx=1, busy=0, req_ready=0, grant=0, lock_timeout=0, lock released, rr_ptr=0, counters 0.
REQ-030 Reset asserted mid-frame truncates the frame; no partial byte is resumed after release.
REQ-031 First accept is possible on the first rising clk edge after rst_n deasserts.

Verification
REQ-032 DELAY_FRAMES=4; req 2 offers 0x41 last=1 -> req_ready[2] one cycle, uartTx 0,1,0,0,0,0,0,1,0,1 each 4 cycles, grant returns to 0, rr_ptr=3.
REQ-033 All four valid, last=1, from reset -> service order 0,1,2,3, accepts 41 cycles apart at DELAY_FRAMES=4.
REQ-034 Req 1 sends 3-byte message (last=0,0,1) while req 0 and 3 valid -> bytes of req 1 contiguous, then req 3, then req 0.
REQ-035 Req 0 sends last=0 then drops valid, LOCK_TIMEOUT=8 -> lock_timeout pulses after 8 idle ARB cycles, req 1 granted next.
REQ-036 rst_n pulsed low during DATA bit 3 -> uartTx=1 and grant=0 asynchronously; next offered byte transmits complete and correct.
